// File: rtl/div_job_sequencer.sv
// Feeds a batch of numerators with one shared denominator into the pipelined
// divider and writes each quotient back by index once the divider latency has elapsed.
module div_job_sequencer #(
    parameter int unsigned NUM_JOBS = 10,
    parameter int unsigned LATENCY  = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_start,
    input  logic [21:0] i_denominator,
    output logic [3:0]  o_numIndex,
    input  logic [31:0] i_numerator,
    output logic [31:0] o_divNumerator,
    output logic [21:0] o_divDenominator,
    input  logic [19:0] i_divQuotient,
    output logic        o_resultWrite,
    output logic [3:0]  o_resultIndex,
    output logic [19:0] o_result,
    output logic        o_busy,
    output logic        o_done
);

    localparam int unsigned IDX_W = 4;
    localparam int unsigned DEN_W = 22;
    localparam int unsigned QUO_W = 20;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_JOBS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [IDX_W-1:0]   cnt;
    logic [IDX_W-1:0]   cnt_nx;
    logic [DEN_W-1:0]   den;
    logic [DEN_W-1:0]   den_nx;
    logic               zero_den;
    logic               zero_den_nx;
    logic               busy;
    logic               done;
    logic               done_nx;
    logic               push;

    // Valid/index shift pipe mirroring the divider latency; the head lines up with i_divQuotient.
    logic [LATENCY-1:0] pipe_vld;
    logic [IDX_W-1:0]   pipe_idx [LATENCY];
    logic               head_vld;
    logic [IDX_W-1:0]   head_idx;

    assign head_vld = pipe_vld[LATENCY-1];
    assign head_idx = pipe_idx[LATENCY-1];

    // Next-state and batch bookkeeping.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        den_nx      = den;
        zero_den_nx = zero_den;
        done_nx     = 1'b0;
        push        = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    den_nx      = i_denominator;
                    zero_den_nx = (i_denominator == '0);
                    cnt_nx      = '0;
                    state_nx    = ISSUE;
                end
            end
            ISSUE: begin
                push = 1'b1;
                if (cnt == LAST_IDX) begin
                    cnt_nx   = '0;
                    state_nx = DRAIN;
                end else begin
                    cnt_nx = cnt + IDX_W'(1);
                end
            end
            DRAIN: begin
                if (head_vld && (head_idx == LAST_IDX)) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            den      <= '0;
            zero_den <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pipe_vld <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                pipe_idx[i] <= '0;
            end
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            den         <= den_nx;
            zero_den    <= zero_den_nx;
            busy        <= (state_nx != IDLE);
            done        <= done_nx;
            pipe_vld[0] <= push;
            pipe_idx[0] <= cnt;
            for (int i = 1; i < int'(LATENCY); i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
        end
    end

    assign o_numIndex       = cnt;
    assign o_divNumerator   = (state == ISSUE) ? i_numerator : '0;
    // Denominator stays at the latched value between batches so the divider never sees a glitch.
    assign o_divDenominator = den;
    assign o_resultWrite    = head_vld;
    assign o_resultIndex    = head_vld ? head_idx : '0;
    assign o_result         = (head_vld && !zero_den) ? i_divQuotient : QUO_W'(0);
    assign o_busy           = busy;
    assign o_done           = done;

endmodule

// File: tb/tb_div_job_sequencer.sv
// Scoreboard bench for div_job_sequencer: a behavioural divider feeds quotients back,
// expected writes and done pulses are queued at stimulus time and checked by a monitor.
module tb_div_job_sequencer;

    localparam int NJ  = 10;
    localparam int LAT = 5;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        i_start = 1'b0;
    logic [21:0] i_denominator = '0;
    logic [3:0]  o_numIndex;
    logic [31:0] i_numerator;
    logic [31:0] o_divNumerator;
    logic [21:0] o_divDenominator;
    logic [19:0] i_divQuotient;
    logic        o_resultWrite;
    logic [3:0]  o_resultIndex;
    logic [19:0] o_result;
    logic        o_busy;
    logic        o_done;

    div_job_sequencer #(.NUM_JOBS(NJ), .LATENCY(LAT)) dut (
        .clock           (clock),
        .reset           (reset),
        .i_start         (i_start),
        .i_denominator   (i_denominator),
        .o_numIndex      (o_numIndex),
        .i_numerator     (i_numerator),
        .o_divNumerator  (o_divNumerator),
        .o_divDenominator(o_divDenominator),
        .i_divQuotient   (i_divQuotient),
        .o_resultWrite   (o_resultWrite),
        .o_resultIndex   (o_resultIndex),
        .o_result        (o_result),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Setup datapath: numerator looked up combinationally by index.
    int nums [16];
    assign i_numerator = 32'(nums[o_numIndex]);

    // Behavioural pipelined divider; a zero denominator yields junk that must be discarded.
    logic [19:0] qp [LAT];
    function automatic logic [19:0] divq(input logic [31:0] n, input logic [21:0] d);
        int ni;
        int di;
        ni = int'($signed(n));
        di = int'($signed(d));
        if (di == 0) return 20'hABCDE;
        return 20'(ni / di);
    endfunction

    always @(posedge clock) begin
        for (int k = LAT - 1; k > 0; k--) qp[k] <= qp[k-1];
        qp[0] <= divq(o_divNumerator, o_divDenominator);
    end
    assign i_divQuotient = qp[LAT-1];

    typedef struct {
        int          idx;
        logic [19:0] res;
        int          cyc;
    } wr_t;

    wr_t         wq[$];
    int          dq[$];
    logic [19:0] exp_res [16];
    logic [21:0] exp_den = '0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    endtask

    // Monitor: pops expectations whenever the DUT writes or signals done.
    always @(negedge clock) begin
        wr_t e;
        int  dc;
        if (o_resultWrite) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", 32'(o_resultWrite), 32'(0));
            end else begin
                e = wq.pop_front();
                chk("wr_index", 32'(o_resultIndex), 32'(e.idx));
                chk("wr_result", 32'(o_result), 32'(e.res));
                chk("wr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (o_done) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", 32'(o_done), 32'(0));
            end else begin
                dc = dq.pop_front();
                chk("done_cycle", 32'(cyc), 32'(dc));
            end
        end
        if (o_busy) chk("den_stable", 32'(o_divDenominator), 32'(exp_den));
    end

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic start_batch(input logic [21:0] d, output int sc);
        i_denominator = d;
        i_start = 1'b1;
        sc = cyc;
        @(posedge clock);
        #1;
        i_start = 1'b0;
    endtask

    task automatic push_batch(input int sc, input int n_writes);
        wr_t e;
        for (int i = 0; i < n_writes; i++) begin
            e.idx = i;
            e.res = exp_res[i];
            e.cyc = sc + 1 + LAT + i;
            wq.push_back(e);
        end
        if (n_writes == NJ) dq.push_back(sc + NJ + LAT + 1);
    endtask

    task automatic drain();
        int t = 0;
        while ((wq.size() != 0 || dq.size() != 0) && t < 200) begin
            @(posedge clock);
            #1;
            t++;
        end
        chk("pending_writes", 32'(wq.size()), 32'(0));
        chk("pending_done", 32'(dq.size()), 32'(0));
        wq.delete();
        dq.delete();
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        int sc2;
        for (int i = 0; i < 16; i++) begin
            nums[i] = 0;
            exp_res[i] = '0;
        end
        for (int k = 0; k < LAT; k++) qp[k] = '0;

        // Reset values
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", 32'(o_busy), 32'(0));
        chk("rst_done", 32'(o_done), 32'(0));
        chk("rst_write", 32'(o_resultWrite), 32'(0));
        chk("rst_result", 32'(o_result), 32'(0));
        chk("rst_rindex", 32'(o_resultIndex), 32'(0));
        chk("rst_numindex", 32'(o_numIndex), 32'(0));
        chk("rst_divden", 32'(o_divDenominator), 32'(0));
        reset = 1'b0;
        @(posedge clock);
        #1;

        // den=4, numerators i*100 -> i*25; busy window check
        for (int i = 0; i < NJ; i++) begin
            nums[i] = i * 100;
            exp_res[i] = 20'(i * 25);
        end
        exp_den = 22'd4;
        start_batch(22'd4, sc);
        push_batch(sc, NJ);
        for (int c = sc + 1; c <= sc + 16; c++) begin
            go_to(c);
            chk("busy_window", 32'(o_busy), 32'(c <= sc + 15));
        end
        drain();

        // den=-3: -10/-3 = 3, 7/-3 = -2
        for (int i = 0; i < NJ; i++) begin
            nums[i] = -10;
            exp_res[i] = 20'h00003;
        end
        nums[9] = 7;
        exp_res[9] = 20'hFFFFE;
        exp_den = 22'h3FFFFD;
        start_batch(22'h3FFFFD, sc);
        push_batch(sc, NJ);
        drain();

        // Zero denominator: full timeline, all results zero
        for (int i = 0; i < NJ; i++) begin
            nums[i] = i * 12345 - 7;
            exp_res[i] = '0;
        end
        exp_den = '0;
        start_batch('0, sc);
        push_batch(sc, NJ);
        drain();

        // Start while busy is ignored; restart in the done cycle
        for (int i = 0; i < NJ; i++) begin
            nums[i] = i * 100;
            exp_res[i] = 20'(i * 25);
        end
        exp_den = 22'd4;
        start_batch(22'd4, sc);
        push_batch(sc, NJ);
        go_to(sc + 5);
        i_denominator = 22'd9;
        i_start = 1'b1;
        @(posedge clock);
        #1;
        i_start = 1'b0;
        go_to(sc + 16);
        for (int i = 0; i < NJ; i++) exp_res[i] = 20'(i * 20);
        exp_den = 22'd5;
        start_batch(22'd5, sc2);
        chk("restart_cycle", 32'(sc2), 32'(sc + 16));
        push_batch(sc2, NJ);
        drain();

        // Reset mid-batch in cycle 8: only indices 0..2 are written
        for (int i = 0; i < NJ; i++) exp_res[i] = 20'(i * 25);
        exp_den = 22'd4;
        start_batch(22'd4, sc);
        push_batch(sc, 3);
        go_to(sc + 8);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("abort_busy", 32'(o_busy), 32'(0));
        chk("abort_write", 32'(o_resultWrite), 32'(0));
        chk("abort_done", 32'(o_done), 32'(0));
        repeat (20) @(posedge clock);
        #1;
        start_batch(22'd4, sc);
        push_batch(sc, NJ);
        drain();

        // Back-to-back den=1: low 20 bits pass unchanged
        for (int i = 0; i < NJ; i++) begin
            nums[i] = (i % 2 == 0) ? 32'h0007FFFF : 32'hFFF80000;
            exp_res[i] = (i % 2 == 0) ? 20'h7FFFF : 20'h80000;
        end
        exp_den = 22'd1;
        start_batch(22'd1, sc);
        push_batch(sc, NJ);
        go_to(sc + 16);
        for (int i = 0; i < NJ; i++) begin
            nums[i] = (i % 2 == 0) ? 32'hFFF80000 : 32'h0007FFFF;
            exp_res[i] = (i % 2 == 0) ? 20'h80000 : 20'h7FFFF;
        end
        start_batch(22'd1, sc2);
        push_batch(sc2, NJ);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
